// File: rtl/regfile_wb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
//   WB_DATA_W / WB_ADDR_W : register data width and register index width
//   REG_COUNT             : number of architectural registers
//   ZERO_REG              : hard-wired zero register index (writes ignored)
//   wb_entry_t            : one buffered long-latency result
//   rd_onehot()           : register index -> one-hot register mask
package regfile_wb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;
    localparam int REG_COUNT = 2 ** WB_ADDR_W;

    localparam logic [WB_ADDR_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic                 valid;
        logic [WB_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0] wd;
    } wb_entry_t;

    function automatic logic [REG_COUNT-1:0] rd_onehot(input logic [WB_ADDR_W-1:0] rd);
        return REG_COUNT'(1) << rd;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of long-latency writeback results.
//   clk, rst_n   : clock, asynchronous active-low reset (clears all entries)
//   push         : write push_entry at the tail (caller guarantees count < DEPTH)
//   pop          : retire the head slot (caller guarantees count > 0)
//   squash_en/rd : clear the valid bit of every stored entry targeting squash_rd;
//                  squashed entries keep their slot until popped
//   head         : entry at the read pointer
//   count        : occupied slots, 0..DEPTH
//   valid_mask   : OR of one-hot(rd) over all valid stored entries
module wb_fifo
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  wb_entry_t            push_entry,
    input  logic                 pop,
    input  logic                 squash_en,
    input  logic [WB_ADDR_W-1:0] squash_rd,
    output wb_entry_t            head,
    output logic [CNT_W-1:0]     count,
    output logic [REG_COUNT-1:0] valid_mask
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (squash_en && mem[i].valid && (mem[i].rd == squash_rd))
                    mem[i].valid <= 1'b0;
            end
            // Popped slots drop their valid bit so the mask only covers live entries.
            if (pop) begin
                mem[rd_ptr].valid <= 1'b0;
                rd_ptr            <= next_ptr(rd_ptr);
            end
            // Push is last so a new entry always wins its slot.
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head = mem[rd_ptr];

    always_comb begin
        valid_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem[i].valid) valid_mask = valid_mask | rd_onehot(mem[i].rd);
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writer-side front end for the register file: merges the never-stalled
// pipeline writeback and a long-latency result stream onto one write port.
//   clk, rst_n            : clock, asynchronous active-low reset
//   pipe_we_i/rd_i/wd_i   : pipeline writeback (rd = 0 means no write)
//   lat_valid_i/ready_o   : long-latency handshake; lat_rd_i/lat_wd_i payload
//   WE3/A3/WD3            : registered regfile write port
//   pend_mask_o           : registers targeted by valid buffered results
//
// Handshake: a long-latency result transfers on any posedge where
// lat_valid_i && lat_ready_o. lat_ready_o depends only on state (FIFO not
// full, out of reset), never on lat_valid_i. A transferred result may be
// dropped (rd = 0, or superseded by a same-cycle pipeline write to the same rd).
//
// Priority each cycle: pipeline write, then FIFO head (valid -> write,
// squashed -> silent pop), then same-cycle bypass when the FIFO is empty.
// A pipeline write is younger than every buffered or same-cycle long-latency
// result, so it squashes matching entries to keep write-after-write order.
// The struct in the package fixes the entry widths; DATA_WIDTH/ADDRESS_WIDTH
// must match WB_DATA_W/WB_ADDR_W.
module regfile_wb_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int DATA_WIDTH    = WB_DATA_W,
    parameter int ADDRESS_WIDTH = WB_ADDR_W,
    parameter int FIFO_DEPTH    = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        pipe_we_i,
    input  logic [ADDRESS_WIDTH-1:0]    pipe_rd_i,
    input  logic [DATA_WIDTH-1:0]       pipe_wd_i,
    input  logic                        lat_valid_i,
    output logic                        lat_ready_o,
    input  logic [ADDRESS_WIDTH-1:0]    lat_rd_i,
    input  logic [DATA_WIDTH-1:0]       lat_wd_i,
    output logic                        WE3,
    output logic [ADDRESS_WIDTH-1:0]    A3,
    output logic [DATA_WIDTH-1:0]       WD3,
    output logic [2**ADDRESS_WIDTH-1:0] pend_mask_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic             pipe_eff;
    logic             lat_accept;
    logic             lat_live;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             fifo_push;
    logic             bypass;
    logic             head_write;
    wb_entry_t        push_entry;
    wb_entry_t        head;
    logic [CNT_W-1:0] fifo_count;

    assign pipe_eff    = pipe_we_i && (pipe_rd_i != ZERO_REG);
    assign lat_ready_o = rst_n && (fifo_count < CNT_W'(FIFO_DEPTH));
    assign lat_accept  = lat_valid_i && lat_ready_o;
    // Accepted result that still needs writing: not x0 and not overwritten by
    // a younger pipeline write to the same register this cycle.
    assign lat_live    = lat_accept && (lat_rd_i != ZERO_REG) &&
                         !(pipe_eff && (lat_rd_i == pipe_rd_i));

    assign fifo_empty  = (fifo_count == '0);
    assign fifo_pop    = !pipe_eff && !fifo_empty;
    assign head_write  = fifo_pop && head.valid;
    assign bypass      = !pipe_eff && fifo_empty && lat_live;
    assign fifo_push   = lat_live && !bypass;
    assign push_entry  = '{valid: 1'b1, rd: lat_rd_i, wd: lat_wd_i};

    wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .squash_en  (pipe_eff),
        .squash_rd  (pipe_rd_i),
        .head       (head),
        .count      (fifo_count),
        .valid_mask (pend_mask_o)
    );

    // A3/WD3 hold their last value when nothing is written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            WE3 <= 1'b0;
            A3  <= '0;
            WD3 <= '0;
        end else begin
            WE3 <= pipe_eff || head_write || bypass;
            if (pipe_eff) begin
                A3  <= pipe_rd_i;
                WD3 <= pipe_wd_i;
            end else if (head_write) begin
                A3  <= head.rd;
                WD3 <= head.wd;
            end else if (bypass) begin
                A3  <= lat_rd_i;
                WD3 <= lat_wd_i;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pipe_we_i;
  logic [AW-1:0] pipe_rd_i;
  logic [DW-1:0] pipe_wd_i;
  logic          lat_valid_i;
  logic          lat_ready_o;
  logic [AW-1:0] lat_rd_i;
  logic [DW-1:0] lat_wd_i;
  logic          WE3;
  logic [AW-1:0] A3;
  logic [DW-1:0] WD3;
  logic [31:0]   pend_mask_o;

  regfile_wb_arbiter #(
    .DATA_WIDTH    (DW),
    .ADDRESS_WIDTH (AW),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pipe_we_i   (pipe_we_i),
    .pipe_rd_i   (pipe_rd_i),
    .pipe_wd_i   (pipe_wd_i),
    .lat_valid_i (lat_valid_i),
    .lat_ready_o (lat_ready_o),
    .lat_rd_i    (lat_rd_i),
    .lat_wd_i    (lat_wd_i),
    .WE3         (WE3),
    .A3          (A3),
    .WD3         (WD3),
    .pend_mask_o (pend_mask_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: a queue of buffered results plus the expected port
  typedef struct {
    bit            v;
    logic [AW-1:0] rd;
    logic [DW-1:0] wd;
  } m_entry_t;

  m_entry_t      mq[$];
  logic          exp_we;
  logic [AW-1:0] exp_a3;
  logic [DW-1:0] exp_wd;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    foreach (mq[i]) if (mq[i].v) m[mq[i].rd] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    mq.delete();
    exp_we = 1'b0;
    exp_a3 = '0;
    exp_wd = '0;
  endtask

  // driver: apply one cycle of inputs, check state-derived outputs before
  // the edge, advance the model, check the write port after the edge
  task automatic step(input logic pwe, input logic [AW-1:0] prd, input logic [DW-1:0] pwd,
                      input logic lv, input logic [AW-1:0] lrd, input logic [DW-1:0] lwd);
    bit ready, acc, pipe_w;
    m_entry_t e;
    pipe_we_i   = pwe;
    pipe_rd_i   = prd;
    pipe_wd_i   = pwd;
    lat_valid_i = lv;
    lat_rd_i    = lrd;
    lat_wd_i    = lwd;
    #1;
    ready = (mq.size() < DEPTH);
    check("lat_ready", 64'(lat_ready_o), 64'(ready));
    check("pend_mask", 64'(pend_mask_o), 64'(model_mask()));

    acc    = lv && ready;
    pipe_w = pwe && (prd != 0);
    e.v = 1'b1; e.rd = lrd; e.wd = lwd;
    if (pipe_w) begin
      foreach (mq[i]) if (mq[i].rd == prd) mq[i].v = 1'b0;
      exp_we = 1'b1; exp_a3 = prd; exp_wd = pwd;
      if (acc && lrd != 0 && lrd != prd) mq.push_back(e);
    end else if (mq.size() > 0) begin
      m_entry_t h = mq.pop_front();
      exp_we = h.v;
      if (h.v) begin exp_a3 = h.rd; exp_wd = h.wd; end
      if (acc && lrd != 0) mq.push_back(e);
    end else if (acc && lrd != 0) begin
      exp_we = 1'b1; exp_a3 = lrd; exp_wd = lwd;
    end else begin
      exp_we = 1'b0;
    end

    @(posedge clk);
    #1;
    check("WE3", 64'(WE3), 64'(exp_we));
    check("A3",  64'(A3),  64'(exp_a3));
    check("WD3", 64'(WD3), 64'(exp_wd));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    // reset held with a valid result offered: nothing may be accepted
    rst_n = 1'b0; pipe_we_i = 1'b0; pipe_rd_i = '0; pipe_wd_i = '0;
    lat_valid_i = 1'b1; lat_rd_i = 5'd3; lat_wd_i = 32'h1234_5678;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_WE3",   64'(WE3), 64'(0));
    check("rst_ready", 64'(lat_ready_o), 64'(0));
    check("rst_pend",  64'(pend_mask_o), 64'(0));
    check("rst_A3",    64'(A3), 64'(0));
    check("rst_WD3",   64'(WD3), 64'(0));
    lat_valid_i = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    idle(1);

    // bypass straight to the write port
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    idle(1);

    // contention: pipe stream x1..x4, late results x7, x9 get buffered
    step(1'b1, 5'd1, 32'hA1, 1'b1, 5'd7, 32'h77);
    step(1'b1, 5'd2, 32'hA2, 1'b1, 5'd9, 32'h99);
    step(1'b1, 5'd3, 32'hA3, 1'b1, 5'd11, 32'hBB);  // FIFO full: not accepted
    step(1'b1, 5'd4, 32'hA4, 1'b0, 5'd0, 32'h0);
    idle(3);

    // squash: buffered x7=0x11 superseded by pipe x7=0x22
    step(1'b1, 5'd1, 32'hC1, 1'b1, 5'd7, 32'h11);
    step(1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 32'h0);
    idle(2);

    // same-cycle squash of an incoming result
    step(1'b1, 5'd6, 32'h66, 1'b1, 5'd6, 32'h55);
    idle(1);

    // zero register on both sources
    step(1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd0, 32'hEEEE);
    idle(2);

    // asynchronous reset with a full FIFO
    step(1'b1, 5'd1, 32'hD1, 1'b1, 5'd7, 32'h70);
    step(1'b1, 5'd2, 32'hD2, 1'b1, 5'd9, 32'h90);
    pipe_we_i = 1'b0; lat_valid_i = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_WE3",   64'(WE3), 64'(0));
    check("mid_rst_pend",  64'(pend_mask_o), 64'(0));
    check("mid_rst_ready", 64'(lat_ready_o), 64'(0));
    @(posedge clk); #1;
    check("mid_rst_hold_WE3", 64'(WE3), 64'(0));
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    idle(3);

    // randomized traffic over a small register range to force collisions
    for (int i = 0; i < 500; i++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
